// File: rtl/stack_cpu.sv
// stack_cpu: multi-cycle stack machine.
// Each instruction takes 2 cycles (FETCH, DECODE), or 4 cycles (plus OPND,
// EXEC) when it carries an operand word. Memory is external and reads
// combinationally.
// Ports:
//   i_clock       rising-edge clock
//   i_reset       synchronous, active-low reset
//   i_run         fetch enable, sampled only in FETCH
//   i_mem_rdata   read data for o_mem_addr, same cycle
//   o_mem_addr    memory address (combinational from state)
//   o_mem_wdata   store data, valid while o_mem_we=1
//   o_mem_we      write strobe; the write happens at the next rising edge
//   o_out_data    value captured by OUT
//   o_out_valid   one-cycle pulse per OUT
//   o_halted      core is stopped after a stack fault
//   o_err_ovf     sticky stack-overflow flag
//   o_err_unf     sticky stack-underflow flag
module stack_cpu #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 16
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_run,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_valid,
  output logic              o_halted,
  output logic              o_err_ovf,
  output logic              o_err_unf
);

  localparam int SW = $clog2(STACK_DEPTH + 1);  // count 0..STACK_DEPTH
  localparam int IW = $clog2(STACK_DEPTH);      // entry index

  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_DEC   = 3'd1;
  localparam logic [2:0] S_OPND  = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_SHL = 4'd2;
  localparam logic [3:0] OP_SHR = 4'd3;
  localparam logic [3:0] OP_SRA = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_LOR = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_PSI = 4'd8;
  localparam logic [3:0] OP_PSH = 4'd9;
  localparam logic [3:0] OP_STR = 4'd10;
  localparam logic [3:0] OP_DUP = 4'd11;
  localparam logic [3:0] OP_JPZ = 4'd12;
  localparam logic [3:0] OP_JPN = 4'd13;
  localparam logic [3:0] OP_OUT = 4'd14;

  localparam logic [DATA_W-1:0] DW_MOD = DATA_W'(DATA_W);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_opnd;
  logic [SW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_stk [STACK_DEPTH];
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_halted;
  logic              r_err_ovf;
  logic              r_err_unf;

  logic [3:0]        w_op;
  logic [IW-1:0]     w_top_idx, w_nxt_idx, w_push_idx;
  logic [DATA_W-1:0] w_a, w_b, w_shamt, w_alu;
  logic              w_is_alu, w_need1, w_pushes, w_unf, w_ovf;
  logic              w_stk_we;
  logic [IW-1:0]     w_stk_idx;
  logic [DATA_W-1:0] w_stk_wd;
  logic              w_unused;

  // Upper instruction bits carry no meaning.
  assign w_unused = ^r_ir[DATA_W-1:4];

  assign w_op       = r_ir[3:0];
  assign w_top_idx  = IW'(r_cnt - SW'(1));
  assign w_nxt_idx  = IW'(r_cnt - SW'(2));
  assign w_push_idx = IW'(r_cnt);
  assign w_b        = r_stk[w_top_idx];
  assign w_a        = r_stk[w_nxt_idx];
  assign w_shamt    = w_b % DW_MOD;

  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_ADD:  w_alu = w_a + w_b;
      OP_SUB:  w_alu = w_a - w_b;
      OP_SHL:  w_alu = w_a << w_shamt;
      OP_SHR:  w_alu = w_a >> w_shamt;
      OP_SRA:  w_alu = $unsigned($signed(w_a) >>> w_shamt);
      OP_AND:  w_alu = w_a & w_b;
      OP_LOR:  w_alu = w_a | w_b;
      OP_XOR:  w_alu = w_a ^ w_b;
      default: w_alu = '0;
    endcase
  end

  // Stack checks, evaluated in DECODE before anything is committed.
  assign w_is_alu = ~w_op[3];
  assign w_need1  = (w_op == OP_DUP) || (w_op == OP_OUT) || (w_op == OP_STR) ||
                    (w_op == OP_JPZ) || (w_op == OP_JPN);
  assign w_pushes = (w_op == OP_PSI) || (w_op == OP_PSH) || (w_op == OP_DUP);
  assign w_unf    = (w_is_alu && (r_cnt < SW'(2))) || (w_need1 && (r_cnt == '0));
  assign w_ovf    = w_pushes && (r_cnt == SW'(STACK_DEPTH));

  // Single stack write port; entries are never reset, only the count is.
  always_comb begin
    w_stk_we  = 1'b0;
    w_stk_idx = w_push_idx;
    w_stk_wd  = w_alu;
    if (i_reset) begin
      if (r_state == S_DEC && !w_unf && !w_ovf) begin
        if (w_is_alu) begin
          w_stk_we  = 1'b1;
          w_stk_idx = w_nxt_idx;
        end else if (w_op == OP_DUP) begin
          w_stk_we = 1'b1;
          w_stk_wd = w_b;
        end
      end else if (r_state == S_EXEC) begin
        if (w_op == OP_PSI) begin
          w_stk_we = 1'b1;
          w_stk_wd = r_opnd;
        end else if (w_op == OP_PSH) begin
          w_stk_we = 1'b1;
          w_stk_wd = i_mem_rdata;
        end
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_stk_we) r_stk[w_stk_idx] <= w_stk_wd;
  end

  always_comb begin
    o_mem_addr = r_pc;
    if (r_state == S_EXEC && (w_op == OP_PSH || w_op == OP_STR))
      o_mem_addr = r_opnd[ADDR_W-1:0];
  end

  // Gating with i_reset keeps a reset that lands on EXEC STR from writing.
  assign o_mem_we    = i_reset && (r_state == S_EXEC) && (w_op == OP_STR);
  assign o_mem_wdata = w_b;

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state     <= S_FETCH;
      r_pc        <= '0;
      r_ir        <= '0;
      r_opnd      <= '0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_halted    <= 1'b0;
      r_err_ovf   <= 1'b0;
      r_err_unf   <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_FETCH: begin
          if (i_run) begin
            r_ir    <= i_mem_rdata;
            r_pc    <= r_pc + ADDR_W'(1);
            r_state <= S_DEC;
          end
        end
        S_DEC: begin
          r_state <= S_FETCH;
          if (w_unf) begin
            r_err_unf <= 1'b1;
            r_halted  <= 1'b1;
            r_state   <= S_HALT;
          end else if (w_ovf) begin
            r_err_ovf <= 1'b1;
            r_halted  <= 1'b1;
            r_state   <= S_HALT;
          end else if (w_is_alu) begin
            r_cnt <= r_cnt - SW'(1);
          end else begin
            case (w_op)
              OP_DUP: r_cnt <= r_cnt + SW'(1);
              OP_OUT: begin
                r_out_data  <= w_b;
                r_out_valid <= 1'b1;
              end
              OP_PSI, OP_PSH, OP_STR, OP_JPZ, OP_JPN: r_state <= S_OPND;
              default: ;
            endcase
          end
        end
        S_OPND: begin
          r_opnd  <= i_mem_rdata;
          r_pc    <= r_pc + ADDR_W'(1);
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_state <= S_FETCH;
          case (w_op)
            OP_PSI, OP_PSH: r_cnt <= r_cnt + SW'(1);
            OP_STR:         r_cnt <= r_cnt - SW'(1);
            OP_JPZ: if (w_b == '0)        r_pc <= r_opnd[ADDR_W-1:0];
            OP_JPN: if (w_b[DATA_W-1])    r_pc <= r_opnd[ADDR_W-1:0];
            default: ;
          endcase
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_halted    = r_halted;
  assign o_err_ovf   = r_err_ovf;
  assign o_err_unf   = r_err_unf;

endmodule

// File: tb/tb_stack_cpu.sv
// tb_stack_cpu: directed programs plus random programs for stack_cpu
// (DATA_W=8, ADDR_W=8, STACK_DEPTH=4). An instruction-level model with a
// queue stack predicts outputs every cycle; literal checks pin the model.
module tb_stack_cpu;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int DEPTH = 4;

  localparam int PH_F = 0, PH_D = 1, PH_O = 2, PH_X = 3, PH_H = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic [DW-1:0] rdata;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          we;
  logic [DW-1:0] out_data;
  logic          out_valid, halted, err_ovf, err_unf;

  always #5 clk = ~clk;

  logic [DW-1:0] mem [256];
  assign rdata = mem[addr];

  stack_cpu #(.DATA_W(DW), .ADDR_W(AW), .STACK_DEPTH(DEPTH)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_run(run), .i_mem_rdata(rdata),
    .o_mem_addr(addr), .o_mem_wdata(wdata), .o_mem_we(we),
    .o_out_data(out_data), .o_out_valid(out_valid), .o_halted(halted),
    .o_err_ovf(err_ovf), .o_err_unf(err_unf)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Reference model state
  int         ph;
  logic [7:0] m_pc, m_ir, m_opnd, m_out;
  bit         m_outv, m_halt, m_eo, m_eu;
  logic [7:0] stk [$];
  logic [7:0] mm [256];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_compare();
    logic [3:0] op;
    bit exp_we;
    op = m_ir[3:0];
    exp_we = rst_n && ph == PH_X && op == 4'd10;
    chk("out_data", out_data, m_out);
    chk("out_valid", out_valid, m_outv);
    chk("halted", halted, m_halt);
    chk("err_ovf", err_ovf, m_eo);
    chk("err_unf", err_unf, m_eu);
    chk("mem_we", we, exp_we);
    if (ph == PH_F || ph == PH_O) chk("mem_addr_pc", addr, m_pc);
    if (ph == PH_X && (op == 4'd9 || op == 4'd10)) chk("mem_addr_opnd", addr, m_opnd);
    if (exp_we) chk("mem_wdata", wdata, stk[$]);
  endtask

  task automatic model_advance();
    logic [3:0] op;
    logic [7:0] a, b, r;
    logic signed [7:0] sa;
    int sh, n;
    if (!rst_n) begin
      ph = PH_F; m_pc = 0; m_ir = 0; m_opnd = 0; m_out = 0;
      m_outv = 0; m_halt = 0; m_eo = 0; m_eu = 0;
      stk.delete();
      return;
    end
    m_outv = 0;
    op = m_ir[3:0];
    n = stk.size();
    case (ph)
      PH_F: if (run) begin m_ir = mm[m_pc]; m_pc = m_pc + 8'd1; ph = PH_D; end
      PH_D: begin
        ph = PH_F;
        if ((op <= 7 && n < 2) || ((op == 11 || op == 14 || op == 10 || op == 12 || op == 13) && n < 1)) begin
          m_eu = 1; m_halt = 1; ph = PH_H;
        end else if ((op == 8 || op == 9 || op == 11) && n == DEPTH) begin
          m_eo = 1; m_halt = 1; ph = PH_H;
        end else if (op <= 7) begin
          b = stk.pop_back();
          a = stk.pop_back();
          sh = b % DW;
          sa = a;
          case (op)
            0: r = a + b;
            1: r = a - b;
            2: r = a << sh;
            3: r = a >> sh;
            4: r = sa >>> sh;
            5: r = a & b;
            6: r = a | b;
            default: r = a ^ b;
          endcase
          stk.push_back(r);
        end else if (op == 11) stk.push_back(stk[$]);
        else if (op == 14) begin m_out = stk[$]; m_outv = 1; end
        else if (op != 15) ph = PH_O;
      end
      PH_O: begin m_opnd = mm[m_pc]; m_pc = m_pc + 8'd1; ph = PH_X; end
      PH_X: begin
        ph = PH_F;
        case (op)
          8:  stk.push_back(m_opnd);
          9:  stk.push_back(mm[m_opnd]);
          10: begin mm[m_opnd] = stk[$]; void'(stk.pop_back()); end
          12: if (stk[$] == 0) m_pc = m_opnd;
          13: if (stk[$][7]) m_pc = m_opnd;
          default: ;
        endcase
      end
      default: ph = PH_H;
    endcase
  endtask

  // One clock: drive inputs at negedge, compare, advance model, apply
  // any DUT store to the bench memory at the rising edge.
  task automatic step(input bit r, input bit rs);
    bit cw;
    logic [7:0] ca, cd;
    run = r;
    rst_n = rs;
    #1;
    if (cmp_en) model_compare();
    cw = we; ca = addr; cd = wdata;
    model_advance();
    @(posedge clk);
    if (cw) mem[ca] = cd;
    @(negedge clk);
  endtask

  task automatic clr(input logic [7:0] fill);
    for (int i = 0; i < 256; i++) begin mem[i] = fill; mm[i] = fill; end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    mem[a] = d; mm[a] = d;
  endtask

  task automatic do_reset();
    step(0, 0);
    step(0, 0);
  endtask

  initial begin
    clr(8'h0F);
    @(negedge clk);
    step(0, 0);
    cmp_en = 1'b1;
    do_reset();
    chk("rst_halted", halted, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_addr", addr, 0);

    // PSI 5, PSI 3, SUB, OUT, ADD (ADD underflows with one entry left)
    clr(8'h0F);
    poke(0, 8'h08); poke(1, 8'h05); poke(2, 8'h08); poke(3, 8'h03);
    poke(4, 8'h01); poke(5, 8'h0E); poke(6, 8'h00);
    do_reset();
    repeat (12) step(1, 1);
    chk("sub_out_valid", out_valid, 1);
    chk("sub_out_data", out_data, 8'h02);
    chk("sub_model_cnt", stk.size(), 1);
    step(1, 1);
    chk("sub_out_valid_drop", out_valid, 0);
    step(1, 1);
    chk("sub_cnt1_unf", err_unf, 1);
    chk("sub_cnt1_halt", halted, 1);

    // PSI 0x81, PSI 1, SRA, STR 0x40, JPZ (underflows on empty stack)
    clr(8'h0F);
    poke(0, 8'h08); poke(1, 8'h81); poke(2, 8'h08); poke(3, 8'h01);
    poke(4, 8'h04); poke(5, 8'h0A); poke(6, 8'h40); poke(7, 8'h0C);
    do_reset();
    repeat (13) step(1, 1);
    chk("str_we", we, 1);
    chk("str_addr", addr, 8'h40);
    chk("str_wdata", wdata, 8'hC0);
    step(1, 1);
    chk("str_mem", mem[8'h40], 8'hC0);
    chk("str_model_cnt", stk.size(), 0);
    repeat (2) step(1, 1);
    chk("str_cnt0_unf", err_unf, 1);

    // PSI 0, JPZ 0x10 -> taken
    clr(8'h0F);
    poke(0, 8'h08); poke(1, 8'h00); poke(2, 8'h0C); poke(3, 8'h10);
    do_reset();
    repeat (8) step(1, 1);
    chk("jpz_taken_pc", addr, 8'h10);
    // PSI 1, JPZ 0x10 -> not taken
    poke(1, 8'h01);
    do_reset();
    repeat (8) step(1, 1);
    chk("jpz_fall_pc", addr, 8'h04);

    // Five PSI at depth 4 -> overflow
    clr(8'h0F);
    for (int i = 0; i < 5; i++) begin poke(8'(2*i), 8'h08); poke(8'(2*i+1), 8'(i+1)); end
    do_reset();
    repeat (18) step(1, 1);
    chk("ovf_halted", halted, 1);
    chk("ovf_flag", err_ovf, 1);
    chk("ovf_no_unf", err_unf, 0);
    chk("ovf_model_cnt", stk.size(), 4);
    chk("ovf_model_pc", m_pc, 9);
    repeat (4) step(1, 1);
    chk("halt_absorb", halted, 1);
    // ADD on empty stack
    clr(8'h00);
    do_reset();
    repeat (2) step(1, 1);
    chk("add_empty_unf", err_unf, 1);
    chk("add_empty_model_pc", m_pc, 1);

    // run=0 hold, then reset during EXEC STR
    clr(8'h0F);
    poke(0, 8'h08); poke(1, 8'h55); poke(2, 8'h0A); poke(3, 8'h30); poke(8'h30, 8'hAA);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(0, 1);
      chk("hold_pc", addr, 0);
      chk("hold_we", we, 0);
    end
    repeat (7) step(1, 1);
    chk("exec_str_we", we, 1);
    rst_n = 1'b0;
    #1;
    chk("str_we_in_reset", we, 0);
    step(1, 0);
    chk("rst_str_nowrite", mem[8'h30], 8'hAA);
    chk("rst_str_addr", addr, 0);
    chk("rst_str_outd", out_data, 0);
    chk("rst_str_halted", halted, 0);

    // PC wrap: jump to NOP at 0xFF, next fetch from 0x00
    clr(8'h0F);
    poke(0, 8'h08); poke(1, 8'h00); poke(2, 8'h0C); poke(3, 8'hFF);
    do_reset();
    repeat (8) step(1, 1);
    chk("wrap_at_ff", addr, 8'hFF);
    repeat (2) step(1, 1);
    chk("wrap_to_00", addr, 8'h00);

    // Random programs, random run stalls, occasional resets
    for (int p = 0; p < 30; p++) begin
      for (int i = 0; i < 256; i++) begin
        logic [7:0] v;
        v = 8'($urandom);
        if ($urandom_range(9) < 4) v[3:0] = 4'd8;
        mem[i] = v; mm[i] = v;
      end
      do_reset();
      for (int c = 0; c < 200; c++) begin
        if ($urandom_range(299) == 0 || (m_halt && $urandom_range(3) == 0))
          step(1, 0);
        else
          step($urandom_range(7) != 0, 1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stack_cpu.md
STACK_CPU -- requirements
Module: stack_cpu

Interface
REQ-001 Parameter DATA_W, 8: data, instruction and stack word width; legal values 8..32.
REQ-002 Parameter ADDR_W, 8: memory address width, with ADDR_W <= DATA_W.
REQ-003 Parameter STACK_DEPTH, 16: number of stack entries; legal values 4..256.
REQ-004 Port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-low reset.
REQ-006 Port run, input, 1: fetch enable; sampled in FETCH only.
REQ-007 Port mem_rdata, input, DATA_W: combinational read data for mem_addr, same cycle.
REQ-008 Port mem_addr, output, ADDR_W: memory address, combinational from state.
REQ-009 Port mem_wdata, output, DATA_W: store data; valid while mem_we=1.
REQ-010 Port mem_we, output, 1: memory write strobe; write occurs at that clock edge.
REQ-011 Port out_data, output, DATA_W: registered value captured by OUT.
REQ-012 Port out_valid, output, 1: registered; one-cycle pulse per OUT.
REQ-013 Port halted, output, 1: registered; core is stopped in HALT.
REQ-014 Port err_ovf / err_unf, output, 1 each: registered sticky stack overflow / underflow flags.

Function
REQ-015 Opcode = ir[3:0]; 0 ADD, 1 SUB, 2 SHL, 3 SHR, 4 SRA, 5 AND, 6 LOR, 7 XOR, 8 PSI, 9 PSH, 10 STR, 11 DUP, 12 JPZ, 13 JPN, 14 OUT, 15 NOP; ir[DATA_W-1:4] is ignored.
REQ-016 States: FETCH, DECODE, OPND, EXEC, HALT.
REQ-017 FETCH, run=1: mem_addr=pc; ir<=mem_rdata; pc<=pc+1; go to DECODE. With run=0: hold state, pc and ir unchanged.
REQ-018 DECODE, ALU ops: pop b (top) and a (next); push a op b; go to FETCH. Stack count decreases by 1. Total latency 2 cycles.
REQ-019 ALU results are modulo 2^DATA_W. SUB = a-b. Shift amount = b mod DATA_W. SHR is zero-fill; SRA replicates a[DATA_W-1].
REQ-020 DECODE, other single-cycle ops: DUP pushes a copy of top; OUT sets out_data<=top and out_valid<=1 with no pop; NOP does nothing. All go to FETCH.
REQ-021 DECODE, ops 8,9,10,12,13: go to OPND. OPND: mem_addr=pc; opnd<=mem_rdata; pc<=pc+1; go to EXEC.
REQ-022 EXEC: PSI pushes opnd. PSH drives mem_addr=opnd[ADDR_W-1:0] and pushes mem_rdata. STR drives mem_addr=opnd, mem_we=1, mem_wdata=top, then pops. JPZ sets pc<=opnd if top==0. JPN sets pc<=opnd if top[DATA_W-1]=1. Jumps do not pop. All go to FETCH. Total latency 4 cycles.
REQ-023 pc is ADDR_W bits and wraps from 2^ADDR_W-1 to 0.
REQ-024 Stack checks are made in DECODE, before any side effect. Underflow: ALU op with count<2, or DUP/OUT/STR/JPZ/JPN with count<1. Overflow: PSI/PSH/DUP with count==STACK_DEPTH.
REQ-025 On a fault: set the matching err flag, set halted, go to HALT. Stack, memory, out_data and opnd are untouched. pc = faulting instruction address +1.
REQ-026 HALT is absorbing until reset: mem_we=0, no fetch, run ignored.
REQ-027 ALU ops at full stack, and DUP at count==STACK_DEPTH-1, are legal and fault-free.
REQ-028 mem_we is 1 only in EXEC for STR, and is forced to 0 while reset=0.
REQ-029 out_valid deasserts on the cycle after OUT.

Reset
REQ-030 reset=0 at a clock edge sets: state=FETCH, pc=0, ir=0, opnd=0, stack count=0, out_data=0, out_valid=0, halted=0, err_ovf=0, err_unf=0.
REQ-031 Reset asserted mid-instruction (including EXEC STR) aborts it: no memory write and no stack change on that edge.
REQ-032 Stack entry contents are not reset; only the count is.

Verification
REQ-033 With DATA_W=8: program PSI 5, PSI 3, SUB, OUT -> out_data=0x02 with a one-cycle out_valid; count=1; 12 cycles from first fetch.
REQ-034 Program PSI 0x81, PSI 1, SRA, STR 0x40 -> mem write of 0xC0 at address 0x40; count=0.
REQ-035 Program PSI 0, JPZ 0x10, with NOP at 0x10 -> pc=0x10 after the jump. Program PSI 1, JPZ 0x10 -> pc=4.
REQ-036 With STACK_DEPTH=4: five PSI -> halted=1, err_ovf=1, count=4, pc=9. Separately, ADD on an empty stack -> err_unf=1, pc=1.
REQ-037 run=0 held for 5 cycles in FETCH -> pc and mem_we unchanged. Reset asserted during EXEC STR -> no write, all outputs at reset values.
REQ-038 pc wrap: NOP at 0xFF with ADDR_W=8 -> next fetch from address 0x00.
